mips_mc_ctrl: RTL

- Multi-cycle MIPS control FSM; sequences the PC counter, instruction register, register file, ALU and unified memory port.
- Decodes the 6-bit opcode and funct fields and emits per-state datapath enables and mux selects.
- Adds a request/ready handshake on memory so slow memory can insert wait states.
- Sits between the instruction register and the datapath; the PC counter's enable is driven from pc_we.

---
 rtl/mips_mc_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with a mem_req/mem_ready wait-state handshake.
// Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to TRAP instead of a NOP.
module mips_mc_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = 4'd13
`endif
  } state_t;

  // Registered Moore controls; the fetch/branch/jump flags are qualified later by mem_ready/zero.
  typedef struct packed {
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_req;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       fetch;
    logic       branch;
    logic       jump;
  } ctl_t;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.fetch = 1'b1; end
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
      S_RWB:    begin c.reg_we = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.branch = 1'b1; end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_ADDIWB: c.reg_we = 1'b1;
      S_JUMP:   begin c.pc_src = 2'd2; c.jump = 1'b1; end
      S_HALT:   c.halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   c.halted = 1'b1;
`endif
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t        state, nxt;
  ctl_t          ctl_q;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          mem_state, timeout;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready && (wait_cnt == LAST);

  always_comb begin
    nxt      = state;
    wait_nxt = '0;
    if (mem_state && !mem_ready) wait_nxt = wait_cnt + CW'(1);
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = (funct == FN_SYSCALL) ? S_HALT : S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = S_TRAP;
`else
          default:      nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   nxt = S_TRAP;
`endif
      default:  nxt = S_FETCH;
    endcase
    if (timeout) nxt = S_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      ctl_q    <= decode(S_FETCH);
    end else begin
      state    <= nxt;
      wait_cnt <= wait_nxt;
      ctl_q    <= decode(nxt);
      if (timeout) bus_err <= 1'b1;
    end
  end

  // rst gates the request and strobes combinationally so an access is abandoned at once.
  assign mem_req    = ctl_q.mem_req & ~rst;
  assign ir_we      = ctl_q.fetch & mem_ready & ~rst;
  assign pc_we      = ~rst & ((ctl_q.fetch & mem_ready) | (ctl_q.branch & zero) | ctl_q.jump);
  assign pc_src     = ctl_q.pc_src;
  assign iord       = ctl_q.iord;
  assign mem_we     = ctl_q.mem_we;
  assign reg_we     = ctl_q.reg_we;
  assign reg_dst    = ctl_q.reg_dst;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign alu_src_a  = ctl_q.alu_src_a;
  assign alu_src_b  = ctl_q.alu_src_b;
  assign alu_op     = ctl_q.alu_op;
  assign halted     = ctl_q.halted;
  assign state_o    = state;

endmodule
